uart_rx_frame: RTL and testbench

//   UART receive framer, directly downstream of the baud generator.
//   - Detects the start bit on the serial input and drives rx_bps_en to the baud generator.
//   - Samples each bit on the rx_bpsclk mid-bit pulse and assembles the character.
//   - Presents the character through a one-entry valid/ready holding register to the APB side.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_rx_sync.sv | 37 +++
 rtl/uart_rx_frame.sv | 170 +++++++++++++++++
 tb/tb_uart_rx_frame.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the UART receive path.
// State encoding covers the optional PARITY state; it is only reachable
// when UART_RX_PARITY_EN is defined.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam logic UART_IDLE_LVL = 1'b1;

    // Number of bits needed to represent values 0..value-1.
    function automatic int clog2(input int value);
        int width;
        width = 0;
        while ((1 << width) < value) begin
            width++;
        end
        return width;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: metastability synchroniser for the async serial line plus a
// 1->0 edge detector. After reset the edge detector stays disarmed until the
// edge flop holds a genuinely sampled value, so a line that is already low
// when reset is released is never mistaken for a start bit.
module uart_rx_sync
    import uart_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk26m,
    input  logic rst26m,
    input  logic rxd_i,
    output logic rxd_s_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   edge_q;
    logic [SYNC_STAGES:0]   vld_q;

    // Shift the line through the synchroniser chain and track which flops hold real samples.
    always_ff @(posedge clk26m) begin
        if (rst26m) begin
            sync_q <= {SYNC_STAGES{UART_IDLE_LVL}};
            edge_q <= UART_IDLE_LVL;
            vld_q  <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rxd_i};
            edge_q <= sync_q[SYNC_STAGES-1];
            vld_q  <= {vld_q[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign rxd_s_o = sync_q[SYNC_STAGES-1];
    assign fall_o  = vld_q[SYNC_STAGES] & edge_q & ~sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: UART receive framer. Finds the start bit, enables the baud
// generator, samples each bit on its mid-bit pulse and hands the character
// to the consumer through a one-entry valid/ready holding register.
// Optional parity checking is built when UART_RX_PARITY_EN is defined;
// otherwise the frame has no parity bit and par_err is tied low.
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk26m,
    input  logic                 rst26m,
    input  logic                 rxd,
    input  logic                 rx_bpsclk,
    output logic                 rx_bps_en,
    input  logic                 parity_odd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frm_err,
    output logic                 par_err,
    output logic                 ovr_err
);

    localparam int CNT_W = clog2(DATA_BITS + 1);

`ifdef UART_RX_PARITY_EN
    localparam state_t AFTER_DATA = PARITY;
`else
    localparam state_t AFTER_DATA = STOP;
`endif

    state_t               state_q;
    logic [CNT_W-1:0]     bit_cnt_q;
    logic [DATA_BITS-1:0] shreg_q;
    logic                 rx_bps_en_q;
    logic                 frm_err_q;
    logic [DATA_BITS-1:0] rx_data_q;
    logic                 rx_valid_q;
    logic                 ovr_err_q;

    logic rxd_s;
    logic rx_fall;
    logic push;

    uart_rx_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk26m (clk26m),
        .rst26m (rst26m),
        .rxd_i  (rxd),
        .rxd_s_o(rxd_s),
        .fall_o (rx_fall)
    );

    // A character is handed over only when its stop bit is sampled high.
    assign push = (state_q == STOP) && rx_bpsclk && rxd_s;

`ifdef UART_RX_PARITY_EN
    logic par_flag_q;
    logic par_err_q;
`endif

    // Frame FSM: start detection, bit sampling, parity/stop handling and baud enable.
    always_ff @(posedge clk26m) begin
        if (rst26m) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            rx_bps_en_q <= 1'b0;
            frm_err_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_flag_q  <= 1'b0;
            par_err_q   <= 1'b0;
`endif
        end else begin
            frm_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (rx_fall) begin
                        state_q     <= START;
                        rx_bps_en_q <= 1'b1;
                    end
                end
                START: begin
                    if (rx_bpsclk) begin
                        if (!rxd_s) begin
                            state_q   <= DATA;
                            bit_cnt_q <= '0;
                        end else begin
                            state_q     <= IDLE;
                            rx_bps_en_q <= 1'b0;
                        end
                    end
                end
                DATA: begin
                    if (rx_bpsclk) begin
                        shreg_q   <= {rxd_s, shreg_q[DATA_BITS-1:1]};
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q == CNT_W'(DATA_BITS - 1)) begin
                            state_q <= AFTER_DATA;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (rx_bpsclk) begin
                        par_flag_q <= (^shreg_q) ^ rxd_s ^ parity_odd;
                        state_q    <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (rx_bpsclk) begin
                        state_q     <= IDLE;
                        rx_bps_en_q <= 1'b0;
                        frm_err_q   <= ~rxd_s;
`ifdef UART_RX_PARITY_EN
                        par_err_q   <= rxd_s & par_flag_q;
`endif
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    rx_bps_en_q <= 1'b0;
                end
            endcase
        end
    end

    // One-entry holding register: load on push when free or being drained, flag overrun otherwise.
    always_ff @(posedge clk26m) begin
        if (rst26m) begin
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            ovr_err_q  <= 1'b0;
        end else begin
            ovr_err_q <= 1'b0;
            if (push) begin
                if (!rx_valid_q || rx_ready) begin
                    rx_data_q  <= shreg_q;
                    rx_valid_q <= 1'b1;
                end else begin
                    ovr_err_q <= 1'b1;
                end
            end else if (rx_valid_q && rx_ready) begin
                rx_valid_q <= 1'b0;
            end
        end
    end

    assign rx_bps_en = rx_bps_en_q;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frm_err   = frm_err_q;
    assign ovr_err   = ovr_err_q;

`ifdef UART_RX_PARITY_EN
    assign par_err = par_err_q;
`else
    logic unused_parity_odd;
    assign unused_parity_odd = parity_odd;
    assign par_err           = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_frame.sv
// tb_uart_rx_frame: self-checking bench for uart_rx_frame paired with a small
// baud generator model (bit period 17 cycles, mid-bit pulse at count 8,
// counter held at 0 while rx_bps_en is low). Expected characters go into a
// scoreboard queue when a frame is driven and are popped on each handshake.
// Parity scenarios are built only with UART_RX_PARITY_EN defined.
module tb_uart_rx_frame;

    localparam int DATA_BITS = 8;
    localparam int BIT_CYC   = 17;
    localparam int MID_CNT   = 8;

    logic                 clk26m     = 1'b0;
    logic                 rst26m     = 1'b1;
    logic                 rxd        = 1'b1;
    logic                 rx_bpsclk;
    logic                 rx_bps_en;
    logic                 parity_odd = 1'b0;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready   = 1'b0;
    logic                 frm_err;
    logic                 par_err;
    logic                 ovr_err;

    int checks = 0;
    int errors = 0;

    int cycle          = 0;
    int lastPulseCycle = 0;
    int validRises     = 0;
    int lastLat        = 0;
    int runLen         = 0;
    int lastRun        = 0;
    int frmCycles      = 0;
    int parCycles      = 0;
    int ovrCycles      = 0;
    int enCycles       = 0;
    logic prevValid    = 1'b0;

    logic [DATA_BITS-1:0] sbQ[$];
    logic [4:0] baudCnt = '0;

    uart_rx_frame #(
        .DATA_BITS  (DATA_BITS),
        .SYNC_STAGES(2)
    ) dut (
        .clk26m    (clk26m),
        .rst26m    (rst26m),
        .rxd       (rxd),
        .rx_bpsclk (rx_bpsclk),
        .rx_bps_en (rx_bps_en),
        .parity_odd(parity_odd),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frm_err   (frm_err),
        .par_err   (par_err),
        .ovr_err   (ovr_err)
    );

    always #19 clk26m = ~clk26m;

    // Baud generator model at baud_div=0: held at zero while disabled, mid-bit pulse at count 8.
    always @(posedge clk26m) begin
        if (rx_bps_en !== 1'b1)              baudCnt <= '0;
        else if (baudCnt == 5'(BIT_CYC - 1)) baudCnt <= '0;
        else                                 baudCnt <= baudCnt + 5'd1;
    end
    assign rx_bpsclk = (rx_bps_en === 1'b1) && (baudCnt == 5'(MID_CNT));

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Monitor: pulse/valid statistics and scoreboard pop on every handshake.
    always @(negedge clk26m) begin
        cycle++;
        if (rx_bpsclk) lastPulseCycle = cycle;
        if (rx_valid === 1'b1 && !prevValid) begin
            validRises++;
            lastLat = cycle - lastPulseCycle;
        end
        if (rx_valid === 1'b1) begin
            runLen++;
        end else begin
            if (prevValid) lastRun = runLen;
            runLen = 0;
        end
        if (frm_err === 1'b1)   frmCycles++;
        if (par_err === 1'b1)   parCycles++;
        if (ovr_err === 1'b1)   ovrCycles++;
        if (rx_bps_en === 1'b1) enCycles++;
        if (rx_valid === 1'b1 && rx_ready === 1'b1) begin
            if (sbQ.size() == 0) checkOutput("sb_unexpected_data", 32'd1, 32'd0);
            else                 checkOutput("sb_data", 32'(rx_data), 32'(sbQ.pop_front()));
        end
        prevValid = (rx_valid === 1'b1);
    end

    task automatic tick();
        @(posedge clk26m);
        #1;
    endtask

    task automatic driveBit(input logic v);
        rxd = v;
        repeat (BIT_CYC) tick();
    endtask

    function automatic logic goodParity(input logic [DATA_BITS-1:0] d);
        return (^d) ^ parity_odd;
    endfunction

    // Drive one complete frame; the character is expected at the consumer when expectData is set.
    task automatic applyStimulus(input logic [DATA_BITS-1:0] d, input logic stopBit,
                                 input logic parBit, input bit expectData);
        if (expectData) sbQ.push_back(d);
        driveBit(1'b0);
        for (int i = 0; i < DATA_BITS; i++) driveBit(d[i]);
`ifdef UART_RX_PARITY_EN
        driveBit(parBit);
`else
        if (parBit === 1'bx) rxd = 1'b1;
`endif
        driveBit(stopBit);
        rxd = 1'b1;
        repeat (4) tick();
    endtask

    task automatic checkResetState(input string phase);
        checkOutput({phase, "_rx_valid"},  32'(rx_valid),  32'd0);
        checkOutput({phase, "_rx_data"},   32'(rx_data),   32'd0);
        checkOutput({phase, "_rx_bps_en"}, 32'(rx_bps_en), 32'd0);
        checkOutput({phase, "_frm_err"},   32'(frm_err),   32'd0);
        checkOutput({phase, "_par_err"},   32'(par_err),   32'd0);
        checkOutput({phase, "_ovr_err"},   32'(ovr_err),   32'd0);
    endtask

    initial begin
        #(38 * 20000);
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int r0, f0, p0, o0, e0;
        logic [DATA_BITS-1:0] d;

        rst26m = 1'b1;
        repeat (3) tick();
        checkResetState("reset");
        rst26m = 1'b0;
        repeat (5) tick();

        // Clean 0xA5 frame with the consumer always ready.
        rx_ready = 1'b1;
        r0 = validRises;
        d  = 8'hA5;
        applyStimulus(d, 1'b1, goodParity(d), 1'b1);
        checkOutput("t1_valid_rises", 32'(validRises - r0), 32'd1);
        checkOutput("t1_latency",     32'(lastLat),         32'd1);
        checkOutput("t1_valid_width", 32'(lastRun),         32'd1);
        checkOutput("t1_bps_en_low",  32'(rx_bps_en),       32'd0);
        checkOutput("t1_sb_drained",  32'(sbQ.size()),      32'd0);

        // Short low glitch: false start aborted at the first mid-bit pulse.
        r0 = validRises; f0 = frmCycles; e0 = enCycles;
        rxd = 1'b0;
        repeat (6) tick();
        rxd = 1'b1;
        repeat (40) tick();
        checkOutput("t2_no_valid",    32'(validRises - r0), 32'd0);
        checkOutput("t2_no_frm",      32'(frmCycles - f0),  32'd0);
        checkOutput("t2_en_cycles",   32'(enCycles - e0),   32'd9);
        checkOutput("t2_bps_en_low",  32'(rx_bps_en),       32'd0);

        // Stop bit forced low: framing error, character discarded.
        r0 = validRises; f0 = frmCycles; p0 = parCycles;
        d  = 8'h3C;
        applyStimulus(d, 1'b0, goodParity(d), 1'b0);
        checkOutput("t3_frm_pulse",   32'(frmCycles - f0),  32'd1);
        checkOutput("t3_no_valid",    32'(validRises - r0), 32'd0);
        checkOutput("t3_no_par",      32'(parCycles - p0),  32'd0);

        // Overrun: second character lost while the first is still held.
        rx_ready = 1'b0;
        o0 = ovrCycles;
        d  = 8'h11;
        applyStimulus(d, 1'b1, goodParity(d), 1'b1);
        checkOutput("t4_no_ovr_first", 32'(ovrCycles - o0), 32'd0);
        d  = 8'h22;
        applyStimulus(d, 1'b1, goodParity(d), 1'b0);
        checkOutput("t4_ovr_pulse",   32'(ovrCycles - o0), 32'd1);
        checkOutput("t4_valid_held",  32'(rx_valid),       32'd1);
        checkOutput("t4_data_held",   32'(rx_data),        32'h11);
        checkOutput("t4_sb_pending",  32'(sbQ.size()),     32'd1);
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        checkOutput("t4_valid_clear", 32'(rx_valid),       32'd0);
        checkOutput("t4_data_kept",   32'(rx_data),        32'h11);
        checkOutput("t4_sb_drained",  32'(sbQ.size()),     32'd0);

`ifdef UART_RX_PARITY_EN
        // Odd parity: 0x07 with parity bit 1 is wrong, with parity bit 0 is right.
        parity_odd = 1'b1;
        rx_ready   = 1'b1;
        p0 = parCycles;
        applyStimulus(8'h07, 1'b1, 1'b1, 1'b1);
        checkOutput("t5_par_pulse",   32'(parCycles - p0), 32'd1);
        checkOutput("t5_bad_sb",      32'(sbQ.size()),     32'd0);
        checkOutput("t5_bad_data",    32'(rx_data),        32'h07);
        p0 = parCycles;
        applyStimulus(8'h07, 1'b1, 1'b0, 1'b1);
        checkOutput("t5_no_par",      32'(parCycles - p0), 32'd0);
        checkOutput("t5_good_sb",     32'(sbQ.size()),     32'd0);
        parity_odd = 1'b0;
`else
        checkOutput("t5_par_tied_low", 32'(parCycles),     32'd0);
`endif

        // Reset in the middle of data bit 4 with a character held; line stays low afterwards.
        rx_ready = 1'b0;
        d = 8'h33;
        applyStimulus(d, 1'b1, goodParity(d), 1'b1);
        checkOutput("t6_held_before", 32'(rx_valid), 32'd1);
        driveBit(1'b0);
        for (int i = 0; i < 4; i++) driveBit(1'b0);
        rxd = 1'b0;
        repeat (8) tick();
        rst26m = 1'b1;
        tick();
        checkResetState("t6_reset");
        sbQ.delete();
        rst26m = 1'b0;
        e0 = enCycles;
        repeat (40) tick();
        checkOutput("t6_low_not_start", 32'(enCycles - e0), 32'd0);
        rxd = 1'b1;
        repeat (10) tick();
        rx_ready = 1'b1;
        r0 = validRises;
        d  = 8'h5A;
        applyStimulus(d, 1'b1, goodParity(d), 1'b1);
        checkOutput("t6_valid_rises", 32'(validRises - r0), 32'd1);
        checkOutput("t6_latency",     32'(lastLat),         32'd1);
        checkOutput("t6_sb_drained",  32'(sbQ.size()),      32'd0);
        checkOutput("t6_bps_en_low",  32'(rx_bps_en),       32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
